lc4_muldiv_seq: RTL

Multi-cycle sequencer for the LC4 MUL, DIV and MOD instructions. The combinational ALU returns 0 for these, so the pipeline routes them here instead. This block owns the busy/stall handshake toward the pipeline and an iterative shift-add multiplier and restoring divider. It sits beside the ALU in the execute stage; the pipeline muxes `o_result` over the ALU result when `o_valid` is high.

---
 rtl/lc4_muldiv_pkg.sv | 13 +
 rtl/lc4_div_step.sv | 23 ++
 rtl/lc4_muldiv_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lc4_muldiv_pkg.sv
// Shared types and decode constants for the LC4 multi-cycle MUL/DIV/MOD sequencer.
package lc4_muldiv_pkg;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
   typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_MOD} op_t;

   localparam logic [3:0] OPC_ARITH = 4'b0001;
   localparam logic [2:0] SUB_MUL   = 3'b001;
   localparam logic [2:0] SUB_DIV   = 3'b011;
   localparam logic [3:0] OPC_MOD   = 4'b1010;
   localparam logic [1:0] SUB_MOD   = 2'b11;

endpackage

// File: rtl/lc4_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, try to subtract.
module lc4_div_step #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] rem,
   input  logic         dvd_msb,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic         q_bit
);

   logic [W:0] partial;
   logic [W:0] divisor_ext;

   always_comb begin
      partial     = {rem, dvd_msb};
      divisor_ext = {1'b0, divisor};
      q_bit       = (partial >= divisor_ext);
      // On restore the partial is below the divisor, so its top bit is always 0.
      rem_next    = q_bit ? W'(partial - divisor_ext) : partial[W-1:0];
   end

endmodule

// File: rtl/lc4_muldiv_seq.sv
// Multi-cycle sequencer for LC4 MUL/DIV/MOD: stall handshake, shift-add multiplier,
// restoring divider built from lc4_div_step.
module lc4_muldiv_seq
   import lc4_muldiv_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_flush,
   input  logic [15:0]          i_insn,
   input  logic [WORD_SIZE-1:0] i_r1data,
   input  logic [WORD_SIZE-1:0] i_r2data,
   output logic                 o_stall,
   output logic                 o_busy,
   output logic                 o_valid,
   output logic [WORD_SIZE-1:0] o_result
);

   localparam int unsigned W     = WORD_SIZE;
   localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

   state_t           state;
   op_t              op;
   op_t              dec_op;
   logic [CNT_W-1:0] count;
   logic             div0;
   logic [2*W-1:0]   mcand;
   logic [2*W-1:0]   acc;
   logic [2*W-1:0]   acc_next;
   logic [W-1:0]     mplier;
   logic [W-1:0]     rem;
   logic [W-1:0]     dvd;
   logic [W-1:0]     divisor;
   logic [W-1:0]     rem_next;
   logic [W-1:0]     quot_next;
   logic [W-1:0]     result_next;
   logic             q_bit;
   logic             is_mul;
   logic             is_div;
   logic             is_mod;
   logic             is_md;
   logic             accept;
   logic             last;
   logic             unused_insn_bits;

   // Instruction decode, from the instruction word alone.
   always_comb begin
      is_mul = (i_insn[15:12] == OPC_ARITH) && (i_insn[5:3] == SUB_MUL);
      is_div = (i_insn[15:12] == OPC_ARITH) && (i_insn[5:3] == SUB_DIV);
      is_mod = (i_insn[15:12] == OPC_MOD) && (i_insn[5:4] == SUB_MOD);
      is_md  = is_mul | is_div | is_mod;
      dec_op = is_mul ? OP_MUL : (is_div ? OP_DIV : OP_MOD);
   end

   assign unused_insn_bits = ^{i_insn[11:6], i_insn[2:0]};

   assign accept  = i_start & is_md & ~i_flush;
   assign o_stall = i_start & is_md & ~o_valid & ~i_flush;

   lc4_div_step #(.W(W)) u_div_step (
      .rem      (rem),
      .dvd_msb  (dvd[W-1]),
      .divisor  (divisor),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // Datapath step values and the result that would be registered on the last step.
   always_comb begin
      acc_next  = acc + (mplier[0] ? mcand : '0);
      quot_next = {dvd[W-2:0], q_bit};
      last      = (count == CNT_W'(W - 1));
      case (op)
         OP_MUL:  result_next = acc_next[W-1:0];
         OP_DIV:  result_next = div0 ? '0 : quot_next;
         OP_MOD:  result_next = div0 ? '0 : rem_next;
         default: result_next = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         op       <= OP_MUL;
         count    <= '0;
         div0     <= 1'b0;
         mcand    <= '0;
         acc      <= '0;
         mplier   <= '0;
         rem      <= '0;
         dvd      <= '0;
         divisor  <= '0;
         o_busy   <= 1'b0;
         o_valid  <= 1'b0;
         o_result <= '0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op      <= dec_op;
                  count   <= '0;
                  div0    <= (i_r2data == '0);
                  mcand   <= {{W{1'b0}}, i_r1data};
                  mplier  <= i_r2data;
                  acc     <= '0;
                  rem     <= '0;
                  dvd     <= i_r1data;
                  divisor <= i_r2data;
                  o_busy  <= 1'b1;
                  state   <= (dec_op == OP_MUL) ? S_MUL : S_DIV;
               end
            end
            S_MUL, S_DIV: begin
               if (i_flush) begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end else begin
                  count <= count + CNT_W'(1);
                  if (state == S_MUL) begin
                     acc    <= acc_next;
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                  end else begin
                     rem <= rem_next;
                     dvd <= quot_next;
                  end
                  // Final step: the result is registered together with the valid pulse.
                  if (last) begin
                     state    <= S_DONE;
                     o_busy   <= 1'b0;
                     o_valid  <= 1'b1;
                     o_result <= result_next;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
